// File: rtl/gpu_stencil_ctrl.sv
// Stencil read-modify-write sequencer in front of gpu_stencil_cache: PSX check/set-mask
// evaluation for 16-pixel spans plus a bulk clear engine that paces cache writes.
module gpu_stencil_ctrl #(
  parameter int CLR_LEN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [14:0]          req_addr_i,
  input  logic [15:0]          req_sel_i,
  input  logic [15:0]          req_bit15_i,
  input  logic                 req_check_i,
  input  logic                 req_set_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [14:0]          out_addr_o,
  output logic [15:0]          out_wen_o,
  input  logic                 clr_start_i,
  input  logic [14:0]          clr_addr_i,
  input  logic [CLR_LEN_W-1:0] clr_len_i,
  output logic                 busy_o,
  output logic                 stencil_rd_req_o,
  output logic [14:0]          stencil_rd_addr_o,
  input  logic [15:0]          stencil_rd_value_i,
  output logic                 stencil_wr_req_o,
  output logic [14:0]          stencil_wr_addr_o,
  output logic [15:0]          stencil_wr_mask_o,
  output logic [15:0]          stencil_wr_value_o,
  input  logic                 stencil_error_i,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    EVAL    = 3'd2,
    CLR_WR  = 3'd3,
    CLR_GAP = 3'd4
  } state_t;

  state_t               state_q;
  logic [14:0]          addr_q;
  logic [15:0]          sel_q;
  logic [15:0]          bit15_q;
  logic                 check_q;
  logic                 set_q;
  logic                 rd_first_q;
  logic [15:0]          word_q;
  logic [14:0]          clr_addr_q;
  logic [CLR_LEN_W-1:0] clr_cnt_q;
  logic                 wr_gap_q;
  logic                 err_q;

  logic [15:0] word;
  logic [15:0] wen;
  logic        req_fire;
  logic        out_fire;

  // Cache data is only present in the first EVAL cycle; afterwards use the captured copy.
  assign word = rd_first_q ? stencil_rd_value_i : word_q;
  assign wen  = sel_q & ~(check_q ? word : 16'h0000);

  assign req_ready_o = !rst_i && (state_q == IDLE) && !clr_start_i;
  assign req_fire    = req_valid_i && req_ready_o;
  assign out_valid_o = !rst_i && (state_q == EVAL) && !wr_gap_q;
  assign out_fire    = out_valid_o && out_ready_i;

  assign out_addr_o  = (state_q == EVAL) ? addr_q : 15'd0;
  assign out_wen_o   = (state_q == EVAL) ? wen : 16'h0000;

  assign stencil_rd_req_o  = !rst_i && (state_q == RD);
  assign stencil_rd_addr_o = (state_q == RD) ? addr_q : 15'd0;

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  always_comb begin
    stencil_wr_req_o   = 1'b0;
    stencil_wr_addr_o  = 15'd0;
    stencil_wr_mask_o  = 16'h0000;
    stencil_wr_value_o = 16'h0000;
    if (!rst_i) begin
      case (state_q)
        EVAL: begin
          if (out_fire && (wen != 16'h0000)) begin
            stencil_wr_req_o   = 1'b1;
            stencil_wr_addr_o  = addr_q;
            stencil_wr_mask_o  = wen;
            stencil_wr_value_o = (bit15_q | {16{set_q}}) & wen;
          end
        end
        CLR_WR: begin
          stencil_wr_req_o   = 1'b1;
          stencil_wr_addr_o  = clr_addr_q;
          stencil_wr_mask_o  = 16'hFFFF;
          stencil_wr_value_o = 16'h0000;
        end
        default: ;
      endcase
    end
  end

  // A clear request takes the IDLE slot ahead of any span presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 15'd0;
      sel_q      <= 16'h0000;
      bit15_q    <= 16'h0000;
      check_q    <= 1'b0;
      set_q      <= 1'b0;
      rd_first_q <= 1'b0;
      word_q     <= 16'h0000;
      clr_addr_q <= 15'd0;
      clr_cnt_q  <= '0;
      wr_gap_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_gap_q   <= stencil_wr_req_o;
      err_q      <= err_q | stencil_error_i;
      rd_first_q <= (state_q == RD);
      case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            if (clr_len_i != '0) begin
              clr_addr_q <= clr_addr_i;
              clr_cnt_q  <= clr_len_i;
              state_q    <= CLR_WR;
            end
          end else if (req_fire) begin
            addr_q  <= req_addr_i;
            sel_q   <= req_sel_i;
            bit15_q <= req_bit15_i;
            check_q <= req_check_i;
            set_q   <= req_set_i;
            state_q <= RD;
          end
        end
        RD: state_q <= EVAL;
        EVAL: begin
          word_q <= word;
          if (out_fire) state_q <= IDLE;
        end
        CLR_WR: begin
          clr_addr_q <= clr_addr_q + 15'd1;
          clr_cnt_q  <= clr_cnt_q - CLR_LEN_W'(1);
          state_q    <= CLR_GAP;
        end
        CLR_GAP: state_q <= (clr_cnt_q != '0) ? CLR_WR : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_stencil_ctrl.sv
// Self-checking bench for gpu_stencil_ctrl: behavioural stencil cache plus a
// word-level reference of the check/set-mask rules.
module tb_gpu_stencil_ctrl;

  localparam int CLR_LEN_W = 16;

  logic                 clk_i;
  logic                 rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [14:0]          req_addr_i;
  logic [15:0]          req_sel_i;
  logic [15:0]          req_bit15_i;
  logic                 req_check_i;
  logic                 req_set_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [14:0]          out_addr_o;
  logic [15:0]          out_wen_o;
  logic                 clr_start_i;
  logic [14:0]          clr_addr_i;
  logic [CLR_LEN_W-1:0] clr_len_i;
  logic                 busy_o;
  logic                 stencil_rd_req_o;
  logic [14:0]          stencil_rd_addr_o;
  logic [15:0]          stencil_rd_value_i;
  logic                 stencil_wr_req_o;
  logic [14:0]          stencil_wr_addr_o;
  logic [15:0]          stencil_wr_mask_o;
  logic [15:0]          stencil_wr_value_o;
  logic                 stencil_error_i;
  logic                 err_o;

  int errors = 0;
  int checks = 0;
  int b2b_viol = 0;
  int wr_count = 0;
  logic prev_wr = 1'b0;

  logic [15:0] cache_mem [0:32767];
  logic [15:0] ref_mem   [0:32767];
  logic        rd_valid_q;
  logic [15:0] rd_data_q;
  logic [15:0] junk_q;
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [15:0] pre_data;

  gpu_stencil_ctrl #(.CLR_LEN_W(CLR_LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_sel_i(req_sel_i), .req_bit15_i(req_bit15_i), .req_check_i(req_check_i),
    .req_set_i(req_set_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_wen_o(out_wen_o), .clr_start_i(clr_start_i),
    .clr_addr_i(clr_addr_i), .clr_len_i(clr_len_i), .busy_o(busy_o),
    .stencil_rd_req_o(stencil_rd_req_o), .stencil_rd_addr_o(stencil_rd_addr_o),
    .stencil_rd_value_i(stencil_rd_value_i), .stencil_wr_req_o(stencil_wr_req_o),
    .stencil_wr_addr_o(stencil_wr_addr_o), .stencil_wr_mask_o(stencil_wr_mask_o),
    .stencil_wr_value_o(stencil_wr_value_o), .stencil_error_i(stencil_error_i),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Cache model: read data valid the cycle after rd_req, junk otherwise.
  always @(posedge clk_i) begin
    junk_q     <= 16'($urandom);
    rd_valid_q <= stencil_rd_req_o;
    if (stencil_rd_req_o) rd_data_q <= cache_mem[stencil_rd_addr_o];
    if (stencil_wr_req_o)
      cache_mem[stencil_wr_addr_o] <= (cache_mem[stencil_wr_addr_o] & ~stencil_wr_mask_o)
                                      | (stencil_wr_value_o & stencil_wr_mask_o);
    if (pre_we) cache_mem[pre_addr] <= pre_data;
  end
  assign stencil_rd_value_i = rd_valid_q ? rd_data_q : junk_q;

  always @(negedge clk_i) begin
    if (stencil_wr_req_o && prev_wr) b2b_viol++;
    if (stencil_wr_req_o) wr_count++;
    prev_wr = stencil_wr_req_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Presents a span and returns just after the accepting edge (DUT in its read cycle).
  task automatic applyStimulus(input logic [14:0] a, input logic [15:0] s, input logic [15:0] b,
                               input logic c, input logic st);
    int n;
    n = 0;
    req_valid_i = 1'b1; req_addr_i = a; req_sel_i = s; req_bit15_i = b;
    req_check_i = c; req_set_i = st;
    #1;
    while (!req_ready_o && n < 50) begin
      tick(); #1; n++;
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL accept_timeout: req_ready=%b want 1", req_ready_o);
    end
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic run_span(input logic [14:0] a, input logic [15:0] s, input logic [15:0] b,
                          input logic c, input logic st, input int hold);
    logic [15:0] ew, ev;
    int wr_before;
    ew = s & ~(c ? ref_mem[a] : 16'h0000);
    ev = (b | {16{st}}) & ew;
    out_ready_i = (hold == 0);
    applyStimulus(a, s, b, c, st);
    #1;
    checks++;
    if (stencil_rd_req_o !== 1'b1 || stencil_rd_addr_o !== a || out_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_cycle: rd_req=%b addr=%h valid=%b want 1 %h 0",
                         stencil_rd_req_o, stencil_rd_addr_o, out_valid_o, a);
    end
    tick(); #1;
    wr_before = wr_count;
    for (int k = 0; k < hold; k++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_wen_o !== ew || out_addr_o !== a || stencil_wr_req_o !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold: valid=%b wen=%h addr=%h wr=%b want 1 %h %h 0",
                           out_valid_o, out_wen_o, out_addr_o, stencil_wr_req_o, ew, a);
      end
      tick(); #1;
    end
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_wen_o !== ew || out_addr_o !== a) begin
      errors++; $display("[TB] FAIL out_beat: valid=%b wen=%h addr=%h want 1 %h %h",
                         out_valid_o, out_wen_o, out_addr_o, ew, a);
    end
    checks++;
    if (stencil_wr_req_o !== (ew != 16'h0000)) begin
      errors++; $display("[TB] FAIL wr_req: got %b want %b", stencil_wr_req_o, ew != 16'h0000);
    end else if (ew != 16'h0000) begin
      checks++;
      if (stencil_wr_addr_o !== a || stencil_wr_mask_o !== ew || stencil_wr_value_o !== ev) begin
        errors++; $display("[TB] FAIL wr_data: addr=%h mask=%h value=%h want %h %h %h",
                           stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o, a, ew, ev);
      end
    end
    tick(); #1;
    checks++;
    if (busy_o !== 1'b0 || stencil_wr_req_o !== 1'b0 || (wr_count - wr_before) != ((ew != 0) ? 1 : 0)) begin
      errors++; $display("[TB] FAIL span_done: busy=%b wr=%b writes=%0d want 0 0 %0d",
                         busy_o, stencil_wr_req_o, wr_count - wr_before, (ew != 0) ? 1 : 0);
    end
    ref_mem[a] = (ref_mem[a] & ~ew) | ev;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || err_o !== 1'b0 ||
        stencil_rd_req_o !== 1'b0 || stencil_wr_req_o !== 1'b0 || out_wen_o !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_state: ready=%b busy=%b valid=%b err=%b rd=%b wr=%b wen=%h",
                         req_ready_o, busy_o, out_valid_o, err_o, stencil_rd_req_o, stencil_wr_req_o, out_wen_o);
    end
  endtask

  task automatic test_check_mask();
    preload(15'h0123, 16'h00F0);
    run_span(15'h0123, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
  endtask

  task automatic test_set_mask();
    preload(15'h0123, 16'h00F0);
    run_span(15'h0123, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    run_span(15'h0123, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0);
  endtask

  task automatic test_skip_all();
    preload(15'h0200, 16'hFFFF);
    run_span(15'h0200, 16'hA5A5, 16'hFFFF, 1'b1, 1'b1, 0);
  endtask

  task automatic test_stall();
    preload(15'h0300, 16'h0F0F);
    run_span(15'h0300, 16'hFF00, 16'h5A5A, 1'b1, 1'b0, 5);
  endtask

  task automatic test_clear();
    preload(15'h7FFE, 16'hABCD);
    preload(15'h7FFF, 16'hABCD);
    preload(15'h0000, 16'hABCD);
    clr_start_i = 1'b0; clr_len_i = '0;
    clr_start_i = 1'b1; clr_len_i = 16'd0; clr_addr_i = 15'h0040;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_zero_ready: got %b want 0", req_ready_o);
    end
    tick();
    clr_start_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stencil_wr_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_zero_noop: busy=%b wr=%b want 0 0", busy_o, stencil_wr_req_o);
    end
    out_ready_i = 1'b1;
    clr_start_i = 1'b1; clr_addr_i = 15'h7FFE; clr_len_i = 16'd3;
    req_valid_i = 1'b1; req_addr_i = 15'h7FFF; req_sel_i = 16'h0003; req_bit15_i = 16'h0000;
    req_check_i = 1'b0; req_set_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_priority: req_ready=%b want 0", req_ready_o);
    end
    tick();
    clr_start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [14:0] ea;
      ea = 15'(32'h7FFE + i / 2);
      #1;
      checks++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0 || stencil_wr_req_o !== (i % 2 == 0)) begin
        errors++; $display("[TB] FAIL clr_cycle%0d: busy=%b ready=%b wr=%b want 1 0 %b",
                           i, busy_o, req_ready_o, stencil_wr_req_o, i % 2 == 0);
      end else if (i % 2 == 0) begin
        checks++;
        if (stencil_wr_addr_o !== ea || stencil_wr_mask_o !== 16'hFFFF || stencil_wr_value_o !== 16'h0) begin
          errors++; $display("[TB] FAIL clr_write%0d: addr=%h mask=%h value=%h want %h ffff 0000",
                             i, stencil_wr_addr_o, stencil_wr_mask_o, stencil_wr_value_o, ea);
        end
      end
      tick();
    end
    ref_mem[15'h7FFE] = 16'h0; ref_mem[15'h7FFF] = 16'h0; ref_mem[15'h0000] = 16'h0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_done: busy=%b ready=%b want 0 1", busy_o, req_ready_o);
    end
    tick();
    req_valid_i = 1'b0;
    #1;
    checks++;
    if (stencil_rd_req_o !== 1'b1 || stencil_rd_addr_o !== 15'h7FFF) begin
      errors++; $display("[TB] FAIL clr_then_span: rd=%b addr=%h want 1 7fff", stencil_rd_req_o, stencil_rd_addr_o);
    end
    tick(); #1;
    checks++;
    if (out_wen_o !== 16'h0003 || stencil_wr_req_o !== 1'b1 || stencil_wr_value_o !== 16'h0003) begin
      errors++; $display("[TB] FAIL clr_span_wen: wen=%h wr=%b value=%h want 0003 1 0003",
                         out_wen_o, stencil_wr_req_o, stencil_wr_value_o);
    end
    tick();
    ref_mem[15'h7FFF] = 16'h0003;
    checks++;
    if (cache_mem[15'h0000] !== 16'h0 || cache_mem[15'h7FFE] !== 16'h0) begin
      errors++; $display("[TB] FAIL clr_contents: [0]=%h [7ffe]=%h want 0 0", cache_mem[15'h0000], cache_mem[15'h7FFE]);
    end
  endtask

  task automatic test_reset_mid_clear();
    clr_start_i = 1'b1; clr_addr_i = 15'h0010; clr_len_i = 16'd4;
    tick();
    clr_start_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (stencil_wr_req_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_cycle_write: wr=%b want 0", stencil_wr_req_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_abandon: busy=%b ready=%b want 0 1", busy_o, req_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int start_viol;
    start_viol = b2b_viol;
    for (int i = 0; i < 8; i++) preload(15'(32'h0400 + i), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      run_span(15'(32'h0400 + $urandom_range(0, 7)), 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 0);
    end
    checks++;
    if (b2b_viol != start_viol || err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL back_to_back: violations=%0d err=%b want 0 0", b2b_viol - start_viol, err_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cache_mem[15'(32'h0400 + i)] !== ref_mem[15'(32'h0400 + i)]) begin
        errors++; $display("[TB] FAIL final_word%0d: got %h want %h", i,
                           cache_mem[15'(32'h0400 + i)], ref_mem[15'(32'h0400 + i)]);
      end
    end
  endtask

  task automatic test_error();
    stencil_error_i = 1'b1;
    tick();
    stencil_error_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("[TB] FAIL err_set: got %b want 1", err_o);
    end
    tick(); tick(); tick(); #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("[TB] FAIL err_sticky: got %b want 1", err_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL err_clear: got %b want 0", err_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_sel_i = '0; req_bit15_i = '0;
    req_check_i = 1'b0; req_set_i = 1'b0; out_ready_i = 1'b1; clr_start_i = 1'b0;
    clr_addr_i = '0; clr_len_i = '0; stencil_error_i = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_check_mask();
    test_set_mask();
    test_skip_all();
    test_stall();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_stencil_ctrl.md
Name: gpu_stencil_ctrl

Overview:
- Read-modify-write sequencer directly upstream of gpu_stencil_cache.
- Takes 16-pixel span requests from the pixel pipeline (one stencil word, 1 bit per pixel) and reads the stencil word.
- Applies PSX check-mask / set-mask rules, then returns per-pixel write enables to the VRAM writer.
- Writes the updated stencil bits back while never issuing back-to-back cache writes.
- Also runs a bulk clear sequencer, used on VRAM fill / reset of mask region.

Parameters:
CLR_LEN_W, 16, width of clear word count (max 32768 words)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  span request valid
req_ready_o  out  1  span request accepted when valid&ready
req_addr_i  in  15  stencil word address {y[8:0],x[9:4]}
req_sel_i  in  16  pixels to draw in span
req_bit15_i  in  16  source pixel bit15 per pixel
req_check_i  in  1  check-mask: skip pixels whose stencil bit=1
req_set_i  in  1  set-mask: force written stencil bit=1
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed
out_addr_o  out  15  echoed word address
out_wen_o  out  16  final per-pixel write enables
clr_start_i  in  1  start clear (pulse)
clr_addr_i  in  15  first word to clear
clr_len_i  in  CLR_LEN_W  word count; 0 = no-op
busy_o  out  1  FSM not in IDLE
stencil_rd_req_o  out  1  to cache
stencil_rd_addr_o  out  15  to cache
stencil_rd_value_i  in  16  cache data, valid 1 cycle after rd_req
stencil_wr_req_o  out  1  to cache
stencil_wr_addr_o  out  15  to cache
stencil_wr_mask_o  out  16  to cache
stencil_wr_value_o  out  16  to cache
stencil_error_i  in  1  cache back-to-back-write error
err_o  out  1  sticky error

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o=1 from the first post-reset cycle; err_o=0; wr_gap_q=0. Reset mid-operation abandons the span or clear; no write is issued in the reset cycle.
- FSM states IDLE, RD, EVAL, CLR_WR, CLR_GAP.
- IDLE: req_ready_o=1.
  - Handshake registers addr/sel/bit15/check/set, then goes to RD.
  - clr_start_i has priority over req_valid_i in the same cycle. That cycle req_ready_o=0 and no span is accepted.
  - clr_len_i=0 stays IDLE. Otherwise latch address/count and go to CLR_WR.
  - clr_start_i outside IDLE is ignored.
- RD (1 cycle): stencil_rd_req_o=1, rd_addr=latched addr; go to EVAL.
- EVAL:
  - Combinational: wen = sel & ~(check ? stencil_rd_value_i : 0).
  - Capture rd_value on entry. Data is only valid the first EVAL cycle; hold it while stalled.
  - out_valid_o=1 only when wr_gap_q=0 (no cache write last cycle).
  - On out_valid&out_ready, if wen!=0, in the same cycle: wr_req_o=1, wr_addr=addr, wr_mask=wen, wr_value=(bit15|{16{set}})&wen. Then go to IDLE.
  - wen=0 still produces an output beat with no write.
- Latency: accept at T, rd_req T+1, out_valid earliest T+2. Max throughput 1 span per 3 cycles.
- Hazard: the next read occurs ≥2 cycles after the write, so masked-write commit inside the cache is always visible. No forwarding needed.
- CLR_WR: wr_req=1, mask=16'hFFFF, value=0, addr=cur. Then addr+=1 (15-bit wrap 0x7FFF→0), count-=1, go to CLR_GAP.
- CLR_GAP: no write; go to CLR_WR if count!=0 else IDLE. Clear of N words takes 2N cycles.
- wr_gap_q <= stencil_wr_req_o every cycle. No two consecutive cycles ever carry stencil_wr_req_o=1.
- err_o sets on stencil_error_i and clears only on reset.
- busy_o=1 in every state except IDLE.

Test Plan:
- Stencil word 0x00F0 at 0x0123; span sel=0xFFFF, check=1, set=0, bit15=0 → out_wen=0xFF0F. Write mask 0xFF0F, value 0. rd_req at T+1, out_valid at T+2.
- Same word, check=0, set=1 → out_wen=0xFFFF, write value 0xFFFF mask 0xFFFF. Next read returns 0xFFFF.
- Stencil 0xFFFF, check=1 → out_wen=0, no stencil_wr_req_o, FSM back to IDLE.
- out_ready_i held low 5 cycles in EVAL → out_valid_o and out_wen_o stable; a single write is issued on release.
- clr_addr=0x7FFE, len=3 → writes at 0x7FFE, 0x7FFF, 0x0000 on alternating cycles; busy_o=1 for 6 cycles. Concurrent req_valid_i is not accepted until IDLE.
- Back-to-back spans with out_ready_i=1 → stencil_wr_req_o never high 2 consecutive cycles; err_o stays 0. Forcing stencil_error_i for 1 cycle → err_o=1 until rst_i.
